// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning HI/LO: fixed-latency multiply(-accumulate), 1 bit/cycle
// restoring divide. Optional MDU_CANCEL_EN adds a Cancel input that aborts an op in flight.
module mdu_iter #(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Start,
  input  logic [3:0]       MDUOp,
`ifdef MDU_CANCEL_EN
  input  logic             Cancel,
`endif
  output logic             Busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int DIV_LAT = WIDTH;
  localparam int CNT_MAX = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int CW      = $clog2(CNT_MAX);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] MUL  = 2'd1;
  localparam logic [1:0] DIV  = 2'd2;

  localparam logic [3:0] OpMult  = 4'd1;
  localparam logic [3:0] OpMultu = 4'd2;
  localparam logic [3:0] OpDiv   = 4'd3;
  localparam logic [3:0] OpDivu  = 4'd4;
  localparam logic [3:0] OpMthi  = 4'd5;
  localparam logic [3:0] OpMtlo  = 4'd6;
  localparam logic [3:0] OpMadd  = 4'd7;
  localparam logic [3:0] OpMaddu = 4'd8;
  localparam logic [3:0] OpMsub  = 4'd9;
  localparam logic [3:0] OpMsubu = 4'd10;

  logic             cancel;
`ifdef MDU_CANCEL_EN
  assign cancel = Cancel;
`else
  assign cancel = 1'b0;
`endif

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             dz_q, dz_d, ovf_q, ovf_d;

  // Multiply datapath works on the latched operands at full 2*WIDTH.
  logic                 mul_signed;
  logic [2*WIDTH-1:0]   mul_a, mul_b, prod, acc, mul_res;

  assign mul_signed = (op_q == OpMult) || (op_q == OpMadd) || (op_q == OpMsub);
  assign mul_a      = mul_signed ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
  assign mul_b      = mul_signed ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
  assign prod       = mul_a * mul_b;
  assign acc        = {hi_q, lo_q};

  always_comb begin
    mul_res = prod;
    if ((op_q == OpMadd) || (op_q == OpMaddu)) begin
      mul_res = acc + prod;
    end else if ((op_q == OpMsub) || (op_q == OpMsubu)) begin
      mul_res = acc - prod;
    end
  end

  // One restoring step: shift the next dividend bit into the remainder, subtract if it fits.
  logic [WIDTH:0]   rem_sh, diff;
  logic             fits;
  logic [WIDTH-1:0] rem_n, quo_n, q_fix, r_fix;

  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs_q};
  assign fits   = ~diff[WIDTH];
  assign rem_n  = fits ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_n  = {quo_q[WIDTH-2:0], fits};
  assign q_fix  = qneg_q ? (~quo_n + 1'b1) : quo_n;
  assign r_fix  = rneg_q ? (~rem_n + 1'b1) : rem_n;

  logic is_mul_op, is_div_op, div_signed;

  assign is_mul_op  = (MDUOp == OpMult) || (MDUOp == OpMultu) || (MDUOp == OpMadd) ||
                      (MDUOp == OpMaddu) || (MDUOp == OpMsub) || (MDUOp == OpMsubu);
  assign is_div_op  = (MDUOp == OpDiv) || (MDUOp == OpDivu);
  assign div_signed = (MDUOp == OpDiv);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (Start && is_mul_op) begin
          a_d     = A;
          b_d     = B;
          op_d    = MDUOp;
          cnt_d   = CW'(MUL_LAT - 1);
          state_d = MUL;
        end else if (Start && is_div_op) begin
          a_d     = A;
          b_d     = B;
          op_d    = MDUOp;
          rem_d   = '0;
          quo_d   = (div_signed && A[WIDTH-1]) ? (~A + 1'b1) : A;
          dvs_d   = (div_signed && B[WIDTH-1]) ? (~B + 1'b1) : B;
          qneg_d  = div_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
          rneg_d  = div_signed && A[WIDTH-1];
          dz_d    = (B == '0);
          ovf_d   = div_signed && (A == {1'b1, {(WIDTH-1){1'b0}}}) && (B == '1);
          cnt_d   = CW'(DIV_LAT - 1);
          state_d = DIV;
        end else if (MDUOp == OpMthi) begin
          hi_d = A;
        end else if (MDUOp == OpMtlo) begin
          lo_d = A;
        end
      end
      MUL: begin
        if (cancel) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          {hi_d, lo_d} = mul_res;
          state_d      = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          rem_d = rem_n;
          quo_d = quo_n;
          if (cnt_q == '0) begin
            state_d = IDLE;
            if (dz_q) begin
              lo_d = '1;
              hi_d = a_q;
            end else if (ovf_q) begin
              lo_d = a_q;
              hi_d = '0;
            end else begin
              lo_d = q_fix;
              hi_d = r_fix;
            end
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
    end
  end

  assign Busy = (state_q != IDLE);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: vector table of ops with hand-computed HI/LO and busy lengths,
// plus sequences for mid-op Start, mthi/mtlo, async reset and (with MDU_CANCEL_EN) Cancel.
module tb_mdu_iter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0;
  logic [31:0] B = '0;
  logic        Start = 1'b0;
  logic [3:0]  MDUOp = '0;
  logic        Busy;
  logic [31:0] HI, LO;
`ifdef MDU_CANCEL_EN
  logic        Cancel = 1'b0;
`endif

  mdu_iter #(.WIDTH(32), .MUL_LAT(5)) dut (
    .clk   (clk),
    .reset (reset),
    .A     (A),
    .B     (B),
    .Start (Start),
    .MDUOp (MDUOp),
`ifdef MDU_CANCEL_EN
    .Cancel(Cancel),
`endif
    .Busy  (Busy),
    .HI    (HI),
    .LO    (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs[NVEC];

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Launch op, count busy cycles, track HI/LO stability while busy. poke>=0 drives a Start/MDUOp
  // of poke_op during that busy cycle; cancel_at>=0 raises Cancel during that busy cycle.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int poke, input logic [3:0] poke_op, input int cancel_at,
                        output int cyc, output logic stable);
    logic [31:0] h0, l0;
    @(negedge clk);
    h0 = HI;
    l0 = LO;
    A = a;
    B = b;
    MDUOp = op;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MDUOp = '0;
    cyc = 0;
    stable = 1'b1;
    while (Busy && cyc < 100) begin
      if (HI !== h0 || LO !== l0) stable = 1'b0;
      if (cyc == poke) begin
        Start = 1'b1;
        MDUOp = poke_op;
        A = 32'hdead_beef;
        B = 32'd3;
      end
`ifdef MDU_CANCEL_EN
      if (cyc == cancel_at) Cancel = 1'b1;
`endif
      @(posedge clk);
      #1;
      Start = 1'b0;
      MDUOp = '0;
`ifdef MDU_CANCEL_EN
      Cancel = 1'b0;
`endif
      cyc++;
    end
    if (cancel_at < 0) begin
      // nothing extra
    end
  endtask

  task automatic set_vec(input int i, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo,
                         input int cyc);
    vecs[i].op  = op;
    vecs[i].a   = a;
    vecs[i].b   = b;
    vecs[i].hi  = hi;
    vecs[i].lo  = lo;
    vecs[i].cyc = cyc;
  endtask

  initial begin
    int          cyc;
    logic        stable;
    logic [31:0] h0, l0;

    // Vectors run in order; accumulate ops depend on the previous row's HI/LO.
    set_vec(0,  4'd1,  32'd3,          32'd5,          32'h0,          32'd15,         5);
    set_vec(1,  4'd3,  32'd13456,      32'd134,        32'd56,         32'd100,        32);
    set_vec(2,  4'd3,  32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFD,  32);
    set_vec(3,  4'd4,  32'hFFFF_FFF9,  32'd2,          32'd1,          32'h7FFF_FFFC,  32);
    set_vec(4,  4'd1,  32'd3,          32'd5,          32'h0,          32'd15,         5);
    set_vec(5,  4'd7,  32'd2,          32'd3,          32'h0,          32'd21,         5);
    set_vec(6,  4'd10, 32'd22,         32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF,  5);
    set_vec(7,  4'd3,  32'h8000_0000,  32'hFFFF_FFFF,  32'h0,          32'h8000_0000,  32);
    set_vec(8,  4'd4,  32'd9,          32'd0,          32'd9,          32'hFFFF_FFFF,  32);
    set_vec(9,  4'd2,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE,  32'h0000_0001,  5);
    set_vec(10, 4'd1,  32'hFFFF_FFFF,  32'd2,          32'hFFFF_FFFF,  32'hFFFF_FFFE,  5);
    set_vec(11, 4'd3,  32'd7,          32'hFFFF_FFFE,  32'd1,          32'hFFFF_FFFD,  32);
    set_vec(12, 4'd3,  32'h8000_0000,  32'd0,          32'h8000_0000,  32'hFFFF_FFFF,  32);
    set_vec(13, 4'd8,  32'd1,          32'd1,          32'h8000_0001,  32'h0000_0000,  5);
    set_vec(14, 4'd9,  32'd2,          32'hFFFF_FFFD,  32'h8000_0001,  32'h0000_0006,  5);
    set_vec(15, 4'd4,  32'd100,        32'd7,          32'd2,          32'd14,         32);
    set_vec(16, 4'd11, 32'd5,          32'd5,          32'd2,          32'd14,         0);

    #100;
    check("reset_busy", {63'd0, Busy}, 64'd0);
    check("reset_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, -1, 4'd0, -1, cyc, stable);
      check($sformatf("v%0d_cycles", i), 64'(cyc), 64'(vecs[i].cyc));
      check($sformatf("v%0d_stable", i), {63'd0, stable}, 64'd1);
      check($sformatf("v%0d_hi", i), {32'd0, HI}, {32'd0, vecs[i].hi});
      check($sformatf("v%0d_lo", i), {32'd0, LO}, {32'd0, vecs[i].lo});
    end

    // Second Start (mult) mid-divide must be ignored.
    run_op(4'd3, 32'd13456, 32'd134, 10, 4'd1, -1, cyc, stable);
    check("midstart_cycles", 64'(cyc), 64'd32);
    check("midstart_hilo", {HI, LO}, {32'd56, 32'd100});

    // mthi while busy is ignored.
    run_op(4'd1, 32'd3, 32'd5, 2, 4'd5, -1, cyc, stable);
    check("mthi_busy_hilo", {HI, LO}, {32'd0, 32'd15});

    // mtlo / mthi in idle: one edge, no Busy, other register untouched.
    @(negedge clk);
    A = 32'h1234;
    MDUOp = 4'd6;
    @(posedge clk);
    #1;
    MDUOp = '0;
    check("mtlo_busy", {63'd0, Busy}, 64'd0);
    check("mtlo_hilo", {HI, LO}, {32'd0, 32'h1234});
    @(negedge clk);
    A = 32'hCAFE_0001;
    MDUOp = 4'd5;
    @(posedge clk);
    #1;
    MDUOp = '0;
    check("mthi_hilo", {HI, LO}, {32'hCAFE_0001, 32'h1234});

`ifdef MDU_CANCEL_EN
    // Cancel during cycle 2 of a madd: aborts, HI/LO keep pre-op values.
    run_op(4'd7, 32'd100, 32'd100, -1, 4'd0, 1, cyc, stable);
    check("cancel_cycles", 64'(cyc), 64'd2);
    check("cancel_hilo", {HI, LO}, {32'hCAFE_0001, 32'h1234});
    // Cancel in idle has no effect on a following op.
    @(negedge clk);
    Cancel = 1'b1;
    @(posedge clk);
    #1;
    Cancel = 1'b0;
    check("cancel_idle_busy", {63'd0, Busy}, 64'd0);
`endif

    // Async reset in cycle 3 of a div clears everything immediately.
    @(negedge clk);
    A = 32'd1000;
    B = 32'd3;
    MDUOp = 4'd3;
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
    MDUOp = '0;
    check("rst_div_busy_before", {63'd0, Busy}, 64'd1);
    repeat (2) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_busy", {63'd0, Busy}, 64'd0);
    check("rst_mid_hilo", {HI, LO}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_after_hilo", {HI, LO}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
